// File: rtl/rr_arb_mux.sv
// Registered N:1 arbitration mux. Round-robin or fixed-priority grant into a
// single output slot that can drain and reload in the same cycle.
module rr_arb_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_chan,
    input  logic            out_ready
);

    logic [N-1:0][W-1:0] data_arr;
    logic [CW-1:0]       ptr;
    logic [CW-1:0]       gnt;
    logic                gnt_found;
    logic                load;
    logic                xfer;

    assign data_arr = in_data;
    assign load     = !out_valid || out_ready;
    assign xfer     = load && gnt_found && !reset;

    // Search order: ascending from 0 in fixed mode, from ptr+1 with wrap in RR.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            if (mode) begin
                idx = k;
            end else begin
                idx = int'(ptr) + 1 + k;
                if (idx >= N) idx = idx - N;
                if (idx >= N) idx = idx - N;
            end
            if (!gnt_found && in_valid[idx]) begin
                gnt       = CW'(idx);
                gnt_found = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= CW'(N - 1);
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= data_arr[gnt];
                out_chan <= gnt;
                ptr      <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: driver runs a spec-level model and queues
// expected words; an independent monitor checks them as the DUT emits them.
module tb_rr_arb_mux;
    localparam int N = 4, W = 8, CW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           mode = 1'b0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_chan;

    rr_arb_mux #(.N(N), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [W-1:0]  data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr = N - 1;
    bit   m_valid = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Spec rule: scan candidates in priority order, first requester wins.
    function automatic int model_grant(bit md, logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = md ? k : (p + 1 + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check grant at negedge, queue expectation, advance model.
    task automatic step();
        int           g;
        bit           ld;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        ld = !m_valid || out_ready;
        g  = (reset || !ld) ? -1 : model_grant(mode, in_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        chk("out_valid", int'(out_valid), int'(m_valid));
        if (g >= 0) q.push_back('{chan: CW'(g), data: in_data[g*W +: W]});
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_ptr   = N - 1;
            q.delete();
        end else if (ld) begin
            m_valid = (g >= 0);
            if (g >= 0) m_ptr = g;
        end
        #1;
    endtask

    // Monitor: whenever a word is presented it must match the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out actual chan=%0d data=%0h expected none", out_chan, out_data);
            end else begin
                chk("out_data", int'(out_data), int'(q[0].data));
                chk("out_chan", int'(out_chan), int'(q[0].chan));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    int rr_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset with everything requesting
        reset = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        in_data = 32'h44332211;
        step(); step();
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_chan", int'(out_chan), 0);
        chk("rst_out_valid", int'(out_valid), 0);

        // Round-robin fairness straight out of reset
        reset = 1'b0; mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq_chan", int'(out_chan), rr_seq[k]);
        end

        // Fixed priority: channel 1 always beats channel 2
        mode = 1'b1; in_valid = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fp_chan", int'(out_chan), 1);
        end

        // Backpressure: load, stall three cycles, then drain+load together
        mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_data = 32'hA5B6C7D8;
        step(); step(); step();
        out_ready = 1'b1;
        step();
        chk("bp_reload_valid", int'(out_valid), 1);

        // Wrap-around: grant 3, then 1001 -> 0, then 1001 -> 3
        in_valid = 4'b1000;
        step();
        chk("wrap_g3", int'(out_chan), 3);
        in_valid = 4'b1001;
        step();
        chk("wrap_g0", int'(out_chan), 0);
        step();
        chk("wrap_g3b", int'(out_chan), 3);

        // Reset while a word is held under backpressure
        in_valid = 4'b0001; in_data = 32'h000000EE;
        step();
        out_ready = 1'b0; in_valid = 4'b0000;
        step();
        reset = 1'b1;
        step();
        chk("midrst_valid", int'(out_valid), 0);
        reset = 1'b0; out_ready = 1'b1;
        step();

        // Randomized traffic with occasional resets and mode flips
        for (int k = 0; k < 400; k++) begin
            in_valid  = N'($urandom);
            in_data   = $urandom;
            mode      = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end

        // Drain and confirm nothing is left outstanding
        reset = 1'b0; in_valid = '0; out_ready = 1'b1;
        step(); step(); step();
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N, default 4: number of input channels, legal range 2..8.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..32.
REQ-003 Parameter CW, default 2: channel-index width, equal to ceil(log2(N)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 in_valid  input  N  per-channel valid; bit i belongs to channel i.
REQ-008 in_data  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-009 in_ready  output  N  per-channel accept strobe; combinational; at most one bit high.
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_data  output  W  registered selected word.
REQ-012 out_chan  output  CW  registered index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-014 Transfer on channel i occurs in a cycle where in_valid[i] && in_ready[i]; downstream transfer occurs where out_valid && out_ready.
REQ-015 Slot free (load enable) = !out_valid || out_ready.
REQ-016 in_ready is all zeros when the slot is not free or no in_valid bit is set.
REQ-017 When the slot is free and at least one in_valid bit is set, exactly one in_ready bit is set: the bit of the granted channel g.
REQ-018 Fixed-priority mode: g = lowest index i with in_valid[i]=1.
REQ-019 Round-robin mode: search starts at (ptr+1) mod N, ascending with wrap-around; g = first index found with in_valid set.
REQ-020 ptr (CW bits, internal) updates to g on every input transfer, in either mode; otherwise it holds.
REQ-021 On an input transfer: out_data <= in_data slice g, out_chan <= g, out_valid <= 1, all at the next edge.
REQ-022 Slot free with no input transfer: out_valid <= 0; out_data and out_chan hold their previous values.
REQ-023 Slot not free (out_valid && !out_ready): out_valid, out_data and out_chan hold; no input is accepted.
REQ-024 Simultaneous drain and load in one cycle is legal. Sustained throughput is one word per cycle while out_ready=1.
REQ-025 Latency from input transfer to out_valid=1 is exactly 1 cycle.
REQ-026 Grant is a pure function of in_valid, mode, ptr and the slot-free condition. It does not depend on out_data or out_chan.
REQ-027 mode may change on any cycle; the new mode takes effect in that same cycle's grant, and ptr is not altered by the change.
REQ-028 in_data of non-granted channels is ignored. An unaccepted channel keeps its request; no request is dropped or latched internally.

Reset
REQ-029 While reset=1 at a rising edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= N-1, so that channel 0 has first round-robin priority.
REQ-030 While reset=1, in_ready is all zeros regardless of in_valid.
REQ-031 Reset asserted mid-transfer discards the held word. No transfer is counted in that cycle, on either side.
REQ-032 The first grant is possible in the first cycle after reset deasserts.

Verification
REQ-033 All scenarios use N=4, W=8.
- Reset: out_ready=1, all in_valid=1, reset=1 for 2 cycles -> in_ready=0000, out_valid=0, out_data=0x00; the first grant after release goes to channel 0.
- Round-robin fairness: mode=0, in_valid=1111 held, out_ready=1, in_data={0x44,0x33,0x22,0x11} -> out_chan sequence 0,1,2,3,0. out_data sequence 0x11,0x22,0x33,0x44,0x11, one word per cycle.
- Fixed priority: mode=1, in_valid=0110 held, out_ready=1 -> every grant goes to channel 1. Channel 2 is never granted.
- Backpressure: one word is loaded, then out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000 and out_data/out_chan are stable for 3 cycles. With out_ready=1, the next word loads in the same cycle as the drain.
- Round-robin wrap-around: after a grant to channel 3, in_valid=1001 -> channel 0 is granted. With ptr=0 and in_valid=1001 -> channel 3 is granted.
- Reset mid-operation: out_valid=1 with out_ready=0, then reset pulse -> out_valid=0 at the next edge and the held word is never transferred.
